// File: rtl/game_render_pkg.sv
// Shared types, default colours and helpers for the obstacle layer renderer.
//   gamemode_e : frame mode (idle / play / pause / end)
//   rgb12_t    : 4:4:4 RGB pixel
//   dim_rgb()  : halves each colour channel for the end-of-game view
package game_render_pkg;

    typedef enum logic [1:0] {
        ModeIdle  = 2'b00,
        ModePlay  = 2'b01,
        ModePause = 2'b10,
        ModeEnd   = 2'b11
    } gamemode_e;

    typedef logic [11:0] rgb12_t;

    localparam rgb12_t DEF_BG_COLOR     = 12'h48C;
    localparam rgb12_t DEF_OBS_COLOR    = 12'hF00;
    localparam rgb12_t DEF_PLAYER_COLOR = 12'h0F0;
    localparam rgb12_t RGB_BLACK        = 12'h000;

    // Shift each 4-bit channel right by one.
    function automatic rgb12_t dim_rgb(input rgb12_t c);
        return {1'b0, c[11:9], 1'b0, c[7:5], 1'b0, c[3:1]};
    endfunction

endpackage

// File: rtl/obstacle_prio_enc.sv
// Lowest-index priority encoder.
//   hit     : request vector, bit 0 has the highest priority
//   idx     : index of the lowest set bit (0 when none set)
//   any_hit : OR of all requests
module obstacle_prio_enc #(
    parameter int unsigned N     = 10,
    parameter int unsigned IDX_W = 4
) (
    input  logic [N-1:0]     hit,
    output logic [IDX_W-1:0] idx,
    output logic             any_hit
);

    always_comb begin
        idx     = '0;
        any_hit = |hit;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (hit[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/obstacle_layer_render.sv
// Pipelined obstacle/player pixel renderer with sticky collision detection.
//   clk, rst_n                    : pixel clock, async active-low reset
//   pix_valid, pix_x, pix_y       : incoming pixel stream
//   frame_start                   : latches obstacle/player/mode inputs into shadow registers
//   gamemode, player_y            : frame mode and player top edge
//   obs_left/right/up/down/en     : per-obstacle half-open boxes and enable mask
//   rgb_out, rgb_valid            : pixel colour, two cycles after pix_*
//   collision, collision_pulse    : sticky flag and first-hit pulse
//   collide_idx                   : lowest obstacle index of the first collision
module obstacle_layer_render
    import game_render_pkg::*;
#(
    parameter int unsigned N_OBS        = 10,
    parameter int unsigned X_W          = 10,
    parameter int unsigned Y_W          = 9,
    parameter int unsigned PLAYER_X     = 80,
    parameter int unsigned PLAYER_W     = 20,
    parameter int unsigned PLAYER_H     = 20,
    parameter rgb12_t      BG_COLOR     = DEF_BG_COLOR,
    parameter rgb12_t      OBS_COLOR    = DEF_OBS_COLOR,
    parameter rgb12_t      PLAYER_COLOR = DEF_PLAYER_COLOR,
    localparam int unsigned IDX_W       = (N_OBS > 1) ? $clog2(N_OBS) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        pix_valid,
    input  logic [X_W-1:0]              pix_x,
    input  logic [Y_W-1:0]              pix_y,
    input  logic                        frame_start,
    input  logic [1:0]                  gamemode,
    input  logic [Y_W-1:0]              player_y,
    input  logic [N_OBS-1:0][X_W-1:0]   obs_left,
    input  logic [N_OBS-1:0][X_W-1:0]   obs_right,
    input  logic [N_OBS-1:0][Y_W-1:0]   obs_up,
    input  logic [N_OBS-1:0][Y_W-1:0]   obs_down,
    input  logic [N_OBS-1:0]            obs_en,
    output logic [11:0]                 rgb_out,
    output logic                        rgb_valid,
    output logic                        collision,
    output logic                        collision_pulse,
    output logic [IDX_W-1:0]            collide_idx
);

    // Player x bounds are fixed; one extra bit keeps PLAYER_X+PLAYER_W from wrapping.
    localparam logic [X_W:0] PX_LO = (X_W + 1)'(PLAYER_X);
    localparam logic [X_W:0] PX_HI = (X_W + 1)'(PLAYER_X + PLAYER_W);
    localparam logic [Y_W:0] PH    = (Y_W + 1)'(PLAYER_H);

    // ---------------------------------------------------------------- shadow registers
    logic [N_OBS-1:0][X_W-1:0] sh_left_q, sh_right_q;
    logic [N_OBS-1:0][Y_W-1:0] sh_up_q, sh_down_q;
    logic [N_OBS-1:0]          sh_en_q;
    logic [Y_W-1:0]            sh_player_y_q;
    gamemode_e                 sh_mode_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_left_q     <= '0;
            sh_right_q    <= '0;
            sh_up_q       <= '0;
            sh_down_q     <= '0;
            sh_en_q       <= '0;
            sh_player_y_q <= '0;
            sh_mode_q     <= ModeIdle;
        end else if (frame_start) begin
            sh_left_q     <= obs_left;
            sh_right_q    <= obs_right;
            sh_up_q       <= obs_up;
            sh_down_q     <= obs_down;
            sh_en_q       <= obs_en;
            sh_player_y_q <= player_y;
            sh_mode_q     <= gamemode_e'(gamemode);
        end
    end

    // ---------------------------------------------------------------- S1: hit test
    // Uses the shadow values as they stand this cycle, so a pixel coinciding with
    // frame_start still sees the previous frame's boxes.
    logic [N_OBS-1:0] hit_d;
    logic             player_hit_d;
    logic [Y_W:0]     py_end;

    always_comb begin
        hit_d = '0;
        for (int i = 0; i < int'(N_OBS); i++) begin
            // Half-open bounds: an inverted or zero-size box can never match.
            hit_d[i] = sh_en_q[i]
                    && (pix_x >= sh_left_q[i]) && (pix_x < sh_right_q[i])
                    && (pix_y >= sh_up_q[i])   && (pix_y < sh_down_q[i]);
        end
    end

    assign py_end       = {1'b0, sh_player_y_q} + PH;
    assign player_hit_d = ({1'b0, pix_x} >= PX_LO) && ({1'b0, pix_x} < PX_HI)
                       && (pix_y >= sh_player_y_q) && ({1'b0, pix_y} < py_end);

    logic [N_OBS-1:0] s1_hit_q;
    logic             s1_player_q;
    logic             s1_valid_q;
    gamemode_e        s1_mode_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_hit_q    <= '0;
            s1_player_q <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_mode_q   <= ModeIdle;
        end else begin
            s1_hit_q    <= hit_d;
            s1_player_q <= player_hit_d;
            s1_valid_q  <= pix_valid;
            s1_mode_q   <= sh_mode_q;
        end
    end

    // ---------------------------------------------------------------- S2: encode + colour
    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;

    obstacle_prio_enc #(
        .N     (N_OBS),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .hit     (s1_hit_q),
        .idx     (enc_idx),
        .any_hit (enc_any)
    );

    rgb12_t           rgb_d, rgb_q, base_rgb;
    logic             rgb_valid_q;
    logic             collision_d, collision_q;
    logic             pulse_d, pulse_q;
    logic [IDX_W-1:0] idx_d, idx_q;

    always_comb begin
        base_rgb = BG_COLOR;
        if (s1_player_q) begin
            base_rgb = PLAYER_COLOR;
        end else if (enc_any) begin
            base_rgb = OBS_COLOR;
        end

        rgb_d       = RGB_BLACK;
        collision_d = collision_q;
        idx_d       = idx_q;
        pulse_d     = 1'b0;

        unique case (s1_mode_q)
            ModeIdle: begin
                if (s1_valid_q) rgb_d = BG_COLOR;
                collision_d = 1'b0;
                idx_d       = '0;
            end
            ModePlay: begin
                if (s1_valid_q) rgb_d = base_rgb;
                if (s1_valid_q && s1_player_q && enc_any && !collision_q) begin
                    collision_d = 1'b1;
                    idx_d       = enc_idx;
                    pulse_d     = 1'b1;
                end
            end
            ModePause: begin
                if (s1_valid_q) rgb_d = base_rgb;
            end
            ModeEnd: begin
                if (s1_valid_q) rgb_d = dim_rgb(base_rgb);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q       <= RGB_BLACK;
            rgb_valid_q <= 1'b0;
            collision_q <= 1'b0;
            pulse_q     <= 1'b0;
            idx_q       <= '0;
        end else begin
            rgb_q       <= rgb_d;
            rgb_valid_q <= s1_valid_q;
            collision_q <= collision_d;
            pulse_q     <= pulse_d;
            idx_q       <= idx_d;
        end
    end

    assign rgb_out         = rgb_q;
    assign rgb_valid       = rgb_valid_q;
    assign collision       = collision_q;
    assign collision_pulse = pulse_q;
    assign collide_idx     = idx_q;

endmodule

// File: tb/tb_obstacle_layer_render.sv
module tb_obstacle_layer_render;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ------------------------------------------------------------ DUT A (defaults)
    logic             rst_n;
    logic             pix_valid;
    logic [9:0]       pix_x;
    logic [8:0]       pix_y;
    logic             frame_start;
    logic [1:0]       gamemode;
    logic [8:0]       player_y;
    logic [9:0][9:0]  obs_left, obs_right;
    logic [9:0][8:0]  obs_up, obs_down;
    logic [9:0]       obs_en;
    logic [11:0]      rgb_out;
    logic             rgb_valid, collision, collision_pulse;
    logic [3:0]       collide_idx;

    obstacle_layer_render u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pix_valid       (pix_valid),
        .pix_x           (pix_x),
        .pix_y           (pix_y),
        .frame_start     (frame_start),
        .gamemode        (gamemode),
        .player_y        (player_y),
        .obs_left        (obs_left),
        .obs_right       (obs_right),
        .obs_up          (obs_up),
        .obs_down        (obs_down),
        .obs_en          (obs_en),
        .rgb_out         (rgb_out),
        .rgb_valid       (rgb_valid),
        .collision       (collision),
        .collision_pulse (collision_pulse),
        .collide_idx     (collide_idx)
    );

    // ------------------------------------------------------------ DUT B (32 obstacles)
    logic              b_pix_valid;
    logic [10:0]       b_pix_x;
    logic [8:0]        b_pix_y;
    logic              b_frame_start;
    logic [31:0][10:0] b_obs_left, b_obs_right;
    logic [31:0][8:0]  b_obs_up, b_obs_down;
    logic [31:0]       b_obs_en;
    logic [11:0]       b_rgb_out;
    logic              b_rgb_valid, b_collision, b_collision_pulse;
    logic [4:0]        b_collide_idx;

    obstacle_layer_render #(
        .N_OBS (32),
        .X_W   (11)
    ) u_dut_b (
        .clk             (clk),
        .rst_n           (rst_n),
        .pix_valid       (b_pix_valid),
        .pix_x           (b_pix_x),
        .pix_y           (b_pix_y),
        .frame_start     (b_frame_start),
        .gamemode        (2'b01),
        .player_y        (9'd300),
        .obs_left        (b_obs_left),
        .obs_right       (b_obs_right),
        .obs_up          (b_obs_up),
        .obs_down        (b_obs_down),
        .obs_en          (b_obs_en),
        .rgb_out         (b_rgb_out),
        .rgb_valid       (b_rgb_valid),
        .collision       (b_collision),
        .collision_pulse (b_collision_pulse),
        .collide_idx     (b_collide_idx)
    );

    // ------------------------------------------------------------ helpers
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_frame(input logic [1:0] mode);
        @(negedge clk);
        gamemode    = mode;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    // One pixel, then check it lands exactly two cycles later.
    task automatic pix_a(input string name, input int x, input int y, input logic [11:0] exp);
        @(negedge clk);
        pix_x     = 10'(x);
        pix_y     = 9'(y);
        pix_valid = 1'b1;
        @(negedge clk);
        pix_valid = 1'b0;
        check({name, "_early"}, 32'(rgb_valid), 32'd0);
        @(negedge clk);
        check({name, "_rgb"}, 32'(rgb_out), 32'(exp));
        check({name, "_vld"}, 32'(rgb_valid), 32'd1);
    endtask

    task automatic pix_b(input string name, input int x, input int y, input logic [11:0] exp);
        @(negedge clk);
        b_pix_x     = 11'(x);
        b_pix_y     = 9'(y);
        b_pix_valid = 1'b1;
        @(negedge clk);
        b_pix_valid = 1'b0;
        @(negedge clk);
        check({name, "_rgb"}, 32'(b_rgb_out), 32'(exp));
        check({name, "_vld"}, 32'(b_rgb_valid), 32'd1);
    endtask

    typedef struct {
        int          x;
        int          y;
        logic [11:0] exp;
    } vec_t;

    vec_t tab [12];

    initial begin
        // player at y 300..319, obs0 box, obs1 zero-width, obs2 inverted
        tab[0]  = '{100, 100, 12'hF00};
        tab[1]  = '{139, 139, 12'hF00};
        tab[2]  = '{140, 100, 12'h48C};
        tab[3]  = '{99,  100, 12'h48C};
        tab[4]  = '{100, 140, 12'h48C};
        tab[5]  = '{120, 99,  12'h48C};
        tab[6]  = '{85,  305, 12'h0F0};
        tab[7]  = '{79,  305, 12'h48C};
        tab[8]  = '{100, 305, 12'h48C};
        tab[9]  = '{85,  319, 12'h0F0};
        tab[10] = '{85,  320, 12'h48C};
        tab[11] = '{50,  10,  12'h48C};

        rst_n       = 1'b0;
        pix_valid   = 1'b0;
        pix_x       = '0;
        pix_y       = '0;
        frame_start = 1'b0;
        gamemode    = 2'b00;
        player_y    = '0;
        obs_left    = '0;
        obs_right   = '0;
        obs_up      = '0;
        obs_down    = '0;
        obs_en      = '0;
        b_pix_valid = 1'b0;
        b_pix_x     = '0;
        b_pix_y     = '0;
        b_frame_start = 1'b0;
        b_obs_left  = '0;
        b_obs_right = '0;
        b_obs_up    = '0;
        b_obs_down  = '0;
        b_obs_en    = '0;

        // Reset held while pixels toggle: everything stays quiet.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pix_valid = ~pix_valid;
            pix_x     = 10'd100;
            pix_y     = 9'd100;
            check("rst_rgb", 32'(rgb_out), 32'd0);
            check("rst_vld", 32'(rgb_valid), 32'd0);
            check("rst_col", 32'(collision), 32'd0);
        end
        @(negedge clk);
        pix_valid = 1'b0;
        rst_n     = 1'b1;

        // Idle shadow after reset: background only.
        pix_a("post_rst", 100, 100, 12'h48C);

        // Play frame with obs0 and two degenerate boxes.
        obs_left[0] = 10'd100; obs_right[0] = 10'd140; obs_up[0] = 9'd100; obs_down[0] = 9'd140;
        obs_left[1] = 10'd50;  obs_right[1] = 10'd50;  obs_up[1] = 9'd0;   obs_down[1] = 9'd20;
        obs_left[2] = 10'd60;  obs_right[2] = 10'd40;  obs_up[2] = 9'd0;   obs_down[2] = 9'd20;
        obs_en      = 10'b00_0000_0111;
        player_y    = 9'd300;
        do_frame(2'b01);
        for (int i = 0; i < 12; i++) begin
            pix_a($sformatf("tab%0d", i), tab[i].x, tab[i].y, tab[i].exp);
        end
        check("tab_nocol", 32'(collision), 32'd0);

        // frame_start coinciding with a pixel: that pixel sees the old shadow.
        @(negedge clk);
        obs_en      = '0;
        frame_start = 1'b1;
        pix_x       = 10'd120;
        pix_y       = 9'd120;
        pix_valid   = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
        pix_valid = 1'b0;
        check("fs_same_old", 32'(rgb_out), 32'h0F00);
        @(negedge clk);
        check("fs_same_new", 32'(rgb_out), 32'h048C);

        // Collision frame.
        obs_en      = 10'b00_0010_1001;
        player_y    = 9'd100;
        obs_left[3] = 10'd90; obs_right[3] = 10'd95; obs_up[3] = 9'd110; obs_down[3] = 9'd120;
        obs_left[5] = 10'd85; obs_right[5] = 10'd99; obs_up[5] = 9'd100; obs_down[5] = 9'd130;
        do_frame(2'b01);
        check("pre_col", 32'(collision), 32'd0);
        pix_a("col_first", 92, 115, 12'h0F0);
        check("col_flag", 32'(collision), 32'd1);
        check("col_idx", 32'(collide_idx), 32'd3);
        check("col_pulse", 32'(collision_pulse), 32'd1);
        @(negedge clk);
        check("col_pulse_off", 32'(collision_pulse), 32'd0);
        pix_a("col_second", 95, 101, 12'h0F0);
        check("col2_pulse", 32'(collision_pulse), 32'd0);
        check("col2_idx", 32'(collide_idx), 32'd3);
        check("col2_flag", 32'(collision), 32'd1);

        // Changing inputs without frame_start has no effect until the next frame.
        obs_left[0] = 10'd200;
        pix_a("shadow_hold", 120, 120, 12'hF00);
        do_frame(2'b01);
        pix_a("shadow_new", 120, 120, 12'h48C);

        // Idle clears collision state and paints background everywhere.
        do_frame(2'b00);
        pix_a("idle_bg", 92, 115, 12'h48C);
        check("idle_col", 32'(collision), 32'd0);
        check("idle_idx", 32'(collide_idx), 32'd0);

        // Pause renders but never flags.
        do_frame(2'b10);
        pix_a("pause_ply", 92, 115, 12'h0F0);
        check("pause_col", 32'(collision), 32'd0);

        // End: dimmed colours, collision frozen.
        do_frame(2'b11);
        pix_a("end_bg", 300, 300, 12'h246);
        pix_a("end_obs", 90, 125, 12'h700);
        pix_a("end_ply", 92, 115, 12'h070);
        check("end_col", 32'(collision), 32'd0);

        // Back to play: fresh collision with lowest index 3.
        do_frame(2'b01);
        pix_a("replay", 92, 112, 12'h0F0);
        check("replay_col", 32'(collision), 32'd1);
        check("replay_pulse", 32'(collision_pulse), 32'd1);

        // Reset mid-stream flushes pipeline and collision state.
        @(negedge clk);
        pix_x     = 10'd92;
        pix_y     = 9'd115;
        pix_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_vld", 32'(rgb_valid), 32'd0);
        check("mid_rst_rgb", 32'(rgb_out), 32'd0);
        check("mid_rst_col", 32'(collision), 32'd0);
        @(negedge clk);
        pix_valid = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        check("after_rst_vld", 32'(rgb_valid), 32'd0);
        pix_a("after_rst", 92, 115, 12'h48C);

        // Wide instance: obstacle 31 only.
        b_obs_left[31] = 11'd990; b_obs_right[31] = 11'd1010;
        b_obs_up[31]   = 9'd40;   b_obs_down[31]  = 9'd60;
        b_obs_en       = 32'h8000_0000;
        @(negedge clk);
        b_frame_start = 1'b1;
        @(negedge clk);
        b_frame_start = 1'b0;
        pix_b("b_obs31", 1000, 50, 12'hF00);
        pix_b("b_edge", 1010, 50, 12'h48C);
        b_obs_en = '0;
        @(negedge clk);
        b_frame_start = 1'b1;
        @(negedge clk);
        b_frame_start = 1'b0;
        pix_b("b_dis31", 1000, 50, 12'h48C);
        check("b_col", 32'(b_collision), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
